// File: rtl/uart_apb_ctrl_if.sv
// uart_apb_ctrl_if: APB bus bundle between a master and the UART control slave.
interface uart_apb_ctrl_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/uart_apb_ctrl.sv
// uart_apb_ctrl: APB register front-end for a UART (DATA/STATUS/BAUD/CTRL) with FIFO strobes and irq.
module uart_apb_ctrl #(
  parameter logic [10:0] BAUD_RESET = 11'd650,
  parameter bit          IRQ_REG    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_apb_ctrl_if.slave        apb,
  output logic                  tx_fifo_write_en_o,
  output logic [7:0]            tx_fifo_data_o,
  input  logic                  tx_fifo_full_i,
  output logic                  rx_fifo_read_en_o,
  input  logic [7:0]            rx_fifo_data_i,
  input  logic                  rx_fifo_empty_i,
  output logic [10:0]           baud_final_value_o,
  output logic                  uart_irq_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_e;
  state_e      state_q, state_d;
  logic [10:0] baud_q, baud_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d, irq_q, irq_d;
  logic [1:0]  sel;
  logic        acc, wr, rd, set_ovf, set_unf, baud_zero, unused;
  assign sel       = apb.paddr[3:2];
  assign acc       = state_q == ACCESS && apb.psel && apb.penable;
  assign wr        = acc && apb.pwrite;
  assign rd        = acc && !apb.pwrite;
  assign set_ovf   = wr && sel == 2'd0 && tx_fifo_full_i;
  assign set_unf   = rd && sel == 2'd0 && rx_fifo_empty_i;
  assign baud_zero = apb.pwdata[10:0] == 11'd0;
  assign unused    = ^{apb.paddr[1:0], apb.pwdata[31:11]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      baud_q   <= BAUD_RESET;
      ctrl_q   <= 2'd0;
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      ctrl_q   <= ctrl_d;
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
      irq_q    <= irq_d;
    end
  end
  // A lone PENABLE in IDLE is ignored; RDWAIT always retires to IDLE even if PSEL drops.
  always_comb begin
    state_d  = state_q == IDLE ? (apb.psel && !apb.penable ? ACCESS : IDLE)
             : rx_fifo_read_en_o ? RDWAIT
             : state_q == ACCESS && apb.psel && !apb.penable ? ACCESS : IDLE;
    tx_ovf_d = set_ovf | (tx_ovf_q & !(wr && sel == 2'd1 && apb.pwdata[2]));
    rx_unf_d = set_unf | (rx_unf_q & !(wr && sel == 2'd1 && apb.pwdata[3]));
    baud_d   = wr && sel == 2'd2 && !baud_zero ? apb.pwdata[10:0] : baud_q;
    ctrl_d   = wr && sel == 2'd3 ? apb.pwdata[1:0] : ctrl_q;
    irq_d    = (ctrl_q[0] & !rx_fifo_empty_i) | (ctrl_q[1] & (tx_ovf_q | rx_unf_q));
  end
  always_comb begin
    tx_fifo_write_en_o = wr && sel == 2'd0 && !tx_fifo_full_i;
    tx_fifo_data_o     = tx_fifo_write_en_o ? apb.pwdata[7:0] : 8'd0;
    rx_fifo_read_en_o  = rd && sel == 2'd0 && !rx_fifo_empty_i;
    apb.pready         = (acc && !rx_fifo_read_en_o) || (state_q == RDWAIT && apb.psel);
    apb.pslverr        = set_ovf || set_unf || (wr && sel == 2'd2 && baud_zero);
    apb.prdata         = state_q == RDWAIT && apb.psel ? {24'd0, rx_fifo_data_i}
                       : !rd || sel == 2'd0 ? 32'd0
                       : sel == 2'd1 ? {28'd0, rx_unf_q, tx_ovf_q, rx_fifo_empty_i, tx_fifo_full_i}
                       : sel == 2'd2 ? {21'd0, baud_q} : {30'd0, ctrl_q};
    baud_final_value_o = baud_q;
    uart_irq_o         = IRQ_REG ? irq_q : irq_d;
  end
endmodule

// File: tb/tb_uart_apb_ctrl.sv
// tb_uart_apb_ctrl: scoreboard bench with a register-level reference model of the UART APB front-end.
module tb_uart_apb_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_apb_ctrl_if apb();
  logic        tx_we, rx_re, tx_full, rx_empty, irq;
  logic [7:0]  tx_data, rx_dout, rx_byte;
  logic [10:0] baud;
  uart_apb_ctrl #(.BAUD_RESET(11'd650), .IRQ_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .apb(apb),
    .tx_fifo_write_en_o(tx_we), .tx_fifo_data_o(tx_data), .tx_fifo_full_i(tx_full),
    .rx_fifo_read_en_o(rx_re), .rx_fifo_data_i(rx_dout), .rx_fifo_empty_i(rx_empty),
    .baud_final_value_o(baud), .uart_irq_o(irq));
  typedef struct {logic [31:0] data; logic err;} rsp_t;
  rsp_t        exp_q[$];
  logic [7:0]  tx_exp[$];
  rsp_t        r_mon;
  int          vectors = 0, errs = 0, pops_exp = 0, pops_act = 0, last_cyc = 0;
  logic [10:0] m_baud;
  logic [1:0]  m_ctrl;
  logic        m_ovf, m_unf;
  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction
  function automatic void model_reset();
    m_baud = 11'd650; m_ctrl = 2'd0; m_ovf = 1'b0; m_unf = 1'b0;
  endfunction
  // Registered RX FIFO: the byte appears the cycle after the pop.
  always @(posedge clk) if (rx_re) rx_dout <= rx_byte;
  always @(negedge clk) begin
    if (apb.pready) begin
      if (exp_q.size() == 0) check("unexpected_pready", 32'(apb.pready), 32'd0);
      else begin
        r_mon = exp_q.pop_front();
        check("prdata", apb.prdata, r_mon.data);
        check("pslverr", 32'(apb.pslverr), 32'(r_mon.err));
      end
    end
    if (tx_we) begin
      if (tx_exp.size() == 0) check("unexpected_push", 32'(tx_we), 32'd0);
      else check("tx_data", 32'(tx_data), 32'(tx_exp.pop_front()));
    end
    if (rx_re) pops_act++;
  end
  task automatic apb_xfer(input logic w, input logic [3:0] a, input logic [31:0] d, input int hold);
    rsp_t r;
    logic [1:0] s;
    int n;
    s = a[3:2]; r.data = 32'd0; r.err = 1'b0;
    if (w) begin
      if (s == 2'd0) begin
        if (tx_full) begin r.err = 1'b1; m_ovf = 1'b1; end
        else tx_exp.push_back(d[7:0]);
      end else if (s == 2'd1) begin
        if (d[2]) m_ovf = 1'b0;
        if (d[3]) m_unf = 1'b0;
      end else if (s == 2'd2) begin
        if (d[10:0] == 11'd0) r.err = 1'b1; else m_baud = d[10:0];
      end else m_ctrl = d[1:0];
    end else begin
      if (s == 2'd0) begin
        if (rx_empty) begin r.err = 1'b1; m_unf = 1'b1; end
        else begin r.data = {24'd0, rx_byte}; pops_exp++; end
      end else if (s == 2'd1) r.data = {28'd0, m_unf, m_ovf, rx_empty, tx_full};
      else if (s == 2'd2) r.data = {21'd0, m_baud};
      else r.data = {30'd0, m_ctrl};
    end
    exp_q.push_back(r);
    @(posedge clk) #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = w; apb.paddr = a; apb.pwdata = d;
    @(posedge clk) #1;
    apb.penable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!apb.pready && n < 4);
    last_cyc = n;
    if (!apb.pready) check("pready_timeout", 32'(apb.pready), 32'd1);
    repeat (hold) @(posedge clk);
    @(posedge clk) #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
    repeat (2) @(negedge clk);
    check("baud", 32'(baud), 32'(m_baud));
    check("irq", 32'(irq), 32'((m_ctrl[0] & !rx_empty) | (m_ctrl[1] & (m_ovf | m_unf))));
  endtask
  task automatic check_reset_outputs(string tag);
    check({tag, "_pready"}, 32'(apb.pready), 32'd0);
    check({tag, "_pslverr"}, 32'(apb.pslverr), 32'd0);
    check({tag, "_prdata"}, apb.prdata, 32'd0);
    check({tag, "_tx_we"}, 32'(tx_we), 32'd0);
    check({tag, "_rx_re"}, 32'(rx_re), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_baud"}, 32'(baud), 32'd650);
    check({tag, "_irq"}, 32'(irq), 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] d;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 4'd0; apb.pwdata = 32'd0;
    tx_full = 1'b0; rx_empty = 1'b1; rx_byte = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk) #1 rst_n = 1'b1;
    // PENABLE without setup must be ignored
    @(posedge clk) #1;
    apb.psel = 1'b1; apb.penable = 1'b1; apb.pwrite = 1'b1; apb.paddr = 4'd0; apb.pwdata = 32'h55;
    repeat (3) begin
      @(negedge clk);
      check("nosetup_pready", 32'(apb.pready), 32'd0);
      check("nosetup_push", 32'(tx_we), 32'd0);
    end
    @(posedge clk) #1 apb.psel = 1'b0; apb.penable = 1'b0;
    apb_xfer(1'b1, 4'h0, 32'h55, 0);
    check("wr_latency", 32'(last_cyc), 32'd1);
    for (int i = 1; i < 8; i++) apb_xfer(1'b1, 4'h0, 32'(i * 17), i % 3);
    tx_full = 1'b1;
    apb_xfer(1'b1, 4'h0, 32'hAA, 0);
    rx_empty = 1'b0;
    apb_xfer(1'b0, 4'h4, 32'd0, 0);
    apb_xfer(1'b1, 4'h4, 32'h4, 0);
    apb_xfer(1'b0, 4'h5, 32'd0, 0);
    tx_full = 1'b0; rx_byte = 8'hF0;
    apb_xfer(1'b0, 4'h0, 32'd0, 0);
    check("rd_latency", 32'(last_cyc), 32'd2);
    rx_empty = 1'b1;
    apb_xfer(1'b0, 4'h0, 32'd0, 0);
    check("rd_empty_latency", 32'(last_cyc), 32'd1);
    apb_xfer(1'b1, 4'h4, 32'hC, 0);
    apb_xfer(1'b0, 4'h8, 32'd0, 0);
    apb_xfer(1'b1, 4'h8, 32'd325, 0);
    apb_xfer(1'b1, 4'hA, 32'h1000, 0);
    apb_xfer(1'b0, 4'hB, 32'd0, 0);
    apb_xfer(1'b1, 4'hC, 32'hFFFF_FFFD, 0);
    apb_xfer(1'b0, 4'hC, 32'd0, 0);
    apb_xfer(1'b1, 4'hC, 32'h1, 0);
    @(posedge clk) #1 rx_empty = 1'b0;
    @(negedge clk) check("irq_before", 32'(irq), 32'd0);
    @(negedge clk) check("irq_after", 32'(irq), 32'd1);
    apb_xfer(1'b1, 4'hC, 32'h0, 0);
    // reset during RDWAIT
    rx_byte = 8'h3C;
    @(posedge clk) #1;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = 4'h0;
    @(posedge clk) #1 apb.penable = 1'b1;
    @(negedge clk) check("abort_pop", 32'(rx_re), 32'd1);
    pops_exp++;
    @(posedge clk) #1 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("abort");
    end
    apb.psel = 1'b0; apb.penable = 1'b0;
    model_reset();
    @(posedge clk) #1 rst_n = 1'b1;
    apb_xfer(1'b0, 4'h4, 32'd0, 0);
    for (int i = 0; i < 300; i++) begin
      tx_full = $urandom_range(0, 3) == 0;
      rx_empty = $urandom_range(0, 2) == 0;
      rx_byte = 8'($urandom);
      d = $urandom;
      if ($urandom_range(0, 4) == 0) d[10:0] = 11'd0;
      apb_xfer(1'($urandom), 4'($urandom), d, $urandom_range(0, 2));
    end
    repeat (3) @(negedge clk);
    check("pop_count", 32'(pops_act), 32'(pops_exp));
    check("rsp_drained", 32'(exp_q.size()), 32'd0);
    check("tx_drained", 32'(tx_exp.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/uart_apb_ctrl.md
UART_APB_CTRL -- requirements
Module: uart_apb_ctrl

Interface
REQ-001 Parameter BAUD_RESET, default 11'd650: baud divisor loaded at reset.
REQ-002 Parameter IRQ_REG, default 1: 1 = uart_irq registered, 0 = combinational.
REQ-003 clk  input  1  single clock for the whole block.
REQ-004 reset  input  1  reset is asynchronous and active-low.
REQ-005 PSEL  input  1  APB select.
REQ-006 PENABLE  input  1  APB enable (access phase).
REQ-007 PWRITE  input  1  1 = write, 0 = read.
REQ-008 PADDR  input  4  byte address; PADDR[3:2] selects the register, PADDR[1:0] is ignored.
REQ-009 PWDATA  input  32  write data.
REQ-010 PRDATA  output  32  read data; valid only while PREADY=1, else 0.
REQ-011 PREADY  output  1  transfer complete.
REQ-012 PSLVERR  output  1  error; valid only while PREADY=1, else 0.
REQ-013 tx_fifo_writeEn  output  1  one-cycle push strobe to the UART TX FIFO.
REQ-014 tx_fifo_dataIn  output  8  TX byte; held stable at least during the writeEn cycle.
REQ-015 tx_fifo_full  input  1  TX FIFO full.
REQ-016 rx_fifo_readEn  output  1  one-cycle pop strobe to the UART RX FIFO.
REQ-017 rx_fifo_dataOut  input  8  RX byte; valid the cycle after readEn (registered FIFO read).
REQ-018 rx_fifo_empty  input  1  RX FIFO empty.
REQ-019 baud_final_value  output  11  divisor to the UART baud generator.
REQ-020 uart_irq  output  1  active-high interrupt.

Function
REQ-021 Register map (PADDR[3:2]) SHALL be: 0 DATA, 1 STATUS, 2 BAUD, 3 CTRL.
REQ-022 FSM states SHALL be IDLE, ACCESS, RDWAIT. Transitions: IDLE->ACCESS on PSEL&!PENABLE; ACCESS->RDWAIT on a valid DATA read; all other ACCESS/RDWAIT cycles return to IDLE once PREADY=1.
REQ-023 PENABLE=1 without a preceding setup cycle SHALL be ignored: PREADY=0, no strobes.
REQ-024 Write DATA with tx_fifo_full=0 SHALL pulse tx_fifo_writeEn for exactly 1 cycle in ACCESS with tx_fifo_dataIn=PWDATA[7:0], and complete that cycle with PREADY=1, PSLVERR=0.
REQ-025 Write DATA with tx_fifo_full=1 SHALL complete with PREADY=1, PSLVERR=1, no push, and set sticky STATUS[2] tx_overflow.
REQ-026 Read DATA with rx_fifo_empty=0 SHALL behave as follows: ACCESS cycle gives rx_fifo_readEn=1, PREADY=0; RDWAIT cycle gives PRDATA={24'b0,rx_fifo_dataOut}, PREADY=1, PSLVERR=0. The total access phase is 2 cycles.
REQ-027 Read DATA with rx_fifo_empty=1 SHALL complete in 1 cycle with PRDATA=0, PSLVERR=1, no pop, and set sticky STATUS[3] rx_underflow.
REQ-028 STATUS read SHALL return {28'b0, rx_underflow, tx_overflow, rx_fifo_empty, tx_fifo_full}; 1-cycle access.
REQ-029 STATUS write SHALL be write-1-to-clear for bits [3:2]; bits [1:0] are read-only. If a set event occurs in the same cycle as a clear of that bit, the set wins.
REQ-030 BAUD write of PWDATA[10:0]!=0 SHALL update baud_final_value the cycle after ACCESS. A write of 0 SHALL keep the old value and return PSLVERR=1. A BAUD read SHALL return the zero-extended divisor.
REQ-031 CTRL SHALL hold bits [1:0]: [0] rx_irq_en, [1] err_irq_en. Bits [31:2] read 0 and writes to them are ignored.
REQ-032 uart_irq SHALL equal (rx_irq_en & !rx_fifo_empty) | (err_irq_en & (tx_overflow|rx_underflow)), registered with 1-cycle delay when IRQ_REG=1.
REQ-033 At most one tx_fifo_writeEn and at most one rx_fifo_readEn pulse SHALL occur per APB transfer, regardless of how long PSEL is held.
REQ-034 PSEL dropping during RDWAIT SHALL still complete the pop internally. The FSM returns to IDLE and the byte is discarded.

Reset
REQ-035 While reset=0, the following SHALL hold: state=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, tx_fifo_writeEn=0, rx_fifo_readEn=0, tx_fifo_dataIn=0, baud_final_value=BAUD_RESET, CTRL=0, sticky flags=0, uart_irq=0.
REQ-036 Reset asserted mid-transfer SHALL abort it immediately; no strobe is emitted after reset asserts, and the next transfer starts from IDLE.

Verification
REQ-037 Write DATA 0x55 with tx_fifo_full=0 -> exactly one writeEn cycle, tx_fifo_dataIn=0x55, PREADY=1, PSLVERR=0.
REQ-038 Nine DATA writes with tx_fifo_full asserted after the 8th -> 8 pushes; 9th returns PSLVERR=1 and STATUS reads 0x5; writing 0x4 to STATUS then reads 0x1.
REQ-039 RX FIFO holds 0xF0; read DATA -> readEn 1 cycle, PREADY low 1 cycle, PRDATA=0x000000F0; read again with rx_fifo_empty=1 -> PSLVERR=1, PRDATA=0.
REQ-040 After reset, BAUD reads 650; write 325 -> baud_final_value=325 next cycle; write 0 -> PSLVERR=1, value stays 325.
REQ-041 CTRL=0x1 and rx_fifo_empty falling -> uart_irq=1 one cycle later; CTRL=0 -> uart_irq=0.
REQ-042 reset=0 asserted during RDWAIT -> all outputs at reset values, no further readEn; next STATUS read completes normally.
